// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and op-class decode for the alu_seq block.
// The build option ALU_SEQ_DIV_EN (used by alu_seq and alu_muldiv_iter) enables DIVU/REMU.
package alu_seq_pkg;
   localparam int ALU_DW  = 32;
   localparam int ALU_OPW = 4;

   localparam logic [3:0] ALU_OP_AND   = 4'b0000;
   localparam logic [3:0] ALU_OP_OR    = 4'b0001;
   localparam logic [3:0] ALU_OP_ADD   = 4'b0010;
   localparam logic [3:0] ALU_OP_XOR   = 4'b0011;
   localparam logic [3:0] ALU_OP_SLL   = 4'b0100;
   localparam logic [3:0] ALU_OP_SRL   = 4'b0101;
   localparam logic [3:0] ALU_OP_SUB   = 4'b0110;
   localparam logic [3:0] ALU_OP_SRA   = 4'b0111;
   localparam logic [3:0] ALU_OP_SLT   = 4'b1000;
   localparam logic [3:0] ALU_OP_SLTU  = 4'b1001;
   localparam logic [3:0] ALU_OP_MUL   = 4'b1010;
   localparam logic [3:0] ALU_OP_MULHU = 4'b1011;
   localparam logic [3:0] ALU_OP_DIVU  = 4'b1100;
   localparam logic [3:0] ALU_OP_REMU  = 4'b1101;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

   function automatic logic is_mul(input logic [3:0] op);
      return (op == ALU_OP_MUL) || (op == ALU_OP_MULHU);
   endfunction

   function automatic logic is_div(input logic [3:0] op);
      return (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
   endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per cycle.
// Divider datapath exists only when ALU_SEQ_DIV_EN is defined.
module alu_muldiv_iter
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = ALU_DW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  hi,
   input  logic                  div,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] result
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic            busy;
   logic            hi_q;
   logic [CW-1:0]   cnt;
   logic [2*W-1:0]  acc;
   logic [2*W-1:0]  acc_nxt;
   logic [W-1:0]    opb;
   logic [W:0]      sum;

   // acc = {high half / remainder, low half / quotient}
   assign sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opb} : '0);

`ifdef ALU_SEQ_DIV_EN
   logic       div_q;
   logic [W:0] rs;
   logic [W:0] diff;

   assign rs   = {acc[2*W-1:W], acc[W-1]};
   assign diff = rs - {1'b0, opb};

   always_comb begin
      acc_nxt = {sum, acc[W-1:1]};
      if (div_q)
         acc_nxt = diff[W] ? {rs[W-1:0], acc[W-2:0], 1'b0}
                           : {diff[W-1:0], acc[W-2:0], 1'b1};
   end
`else
   logic unused_div;
   assign unused_div = div;
   assign acc_nxt    = {sum, acc[W-1:1]};
`endif

   assign done   = busy & (cnt == LAST);
   assign result = hi_q ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         opb   <= '0;
         hi_q  <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
         div_q <= 1'b0;
`endif
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= '0;
         acc   <= {{W{1'b0}}, a};
         opb   <= b;
         hi_q  <= hi;
`ifdef ALU_SEQ_DIV_EN
         div_q <= div;
`endif
      end else if (busy) begin
         acc <= acc_nxt;
         cnt <= done ? '0 : cnt + CW'(1);
         if (done) busy <= 1'b0;
      end
   end
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshakes: FSM, single-cycle datapath, MUL/DIV via alu_muldiv_iter.
// ALU_SEQ_DIV_EN defined -> DIVU/REMU supported; undefined -> they report op_err.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int DATA_WIDTH = ALU_DW,
   parameter int OP_WIDTH   = ALU_OPW
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic [OP_WIDTH-1:0]   alu_opcode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] alu_result,
   output logic                  zero,
   output logic                  op_err
);
   localparam int SHW = $clog2(DATA_WIDTH);

   state_e                state;
   logic [3:0]            op;
   logic                  accept;
   logic                  iter;
   logic                  err;
   logic [DATA_WIDTH-1:0] res;
   logic [SHW-1:0]        shamt;
   logic                  md_done;
   logic [DATA_WIDTH-1:0] md_res;

   assign op        = alu_opcode;
   assign shamt     = b[SHW-1:0];
   assign in_ready  = rst_n & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
   assign accept    = in_valid & in_ready;
   assign out_valid = (state == ST_DONE);

   always_comb begin
      res  = '0;
      err  = 1'b0;
      iter = 1'b0;
      case (op)
         ALU_OP_AND:   res = a & b;
         ALU_OP_OR:    res = a | b;
         ALU_OP_ADD:   res = a + b;
         ALU_OP_SUB:   res = a - b;
         ALU_OP_XOR:   res = a ^ b;
         ALU_OP_SLL:   res = a << shamt;
         ALU_OP_SRL:   res = a >> shamt;
         ALU_OP_SRA:   res = $signed(a) >>> shamt;
         ALU_OP_SLT:   res = DATA_WIDTH'($signed(a) < $signed(b));
         ALU_OP_SLTU:  res = DATA_WIDTH'(a < b);
         ALU_OP_MUL,
         ALU_OP_MULHU: iter = 1'b1;
`ifdef ALU_SEQ_DIV_EN
         // divide by zero skips iteration and answers immediately
         ALU_OP_DIVU:  if (b == '0) res = '1; else iter = 1'b1;
         ALU_OP_REMU:  if (b == '0) res = a;  else iter = 1'b1;
`endif
         default:      err = 1'b1;
      endcase
   end

   alu_muldiv_iter #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept & iter),
      .hi     ((op == ALU_OP_MULHU) | (op == ALU_OP_REMU)),
      .div    (is_div(op)),
      .a      (a),
      .b      (b),
      .done   (md_done),
      .result (md_res)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         alu_result <= '0;
         zero       <= 1'b1;
         op_err     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (iter) begin
                     state <= ST_BUSY;
                  end else begin
                     state      <= ST_DONE;
                     alu_result <= res;
                     zero       <= (res == '0);
                     op_err     <= err;
                  end
               end else if (state == ST_DONE && out_ready) begin
                  state <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               if (md_done) begin
                  state      <= ST_DONE;
                  alu_result <= md_res;
                  zero       <= (md_res == '0);
                  op_err     <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: arithmetic model + scoreboard check every output cycle, plus literal checks.
module tb_alu_seq;
   import alu_seq_pkg::*;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         out_ready = 1'b1;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [3:0]   alu_opcode = 4'h0;
   logic         in_ready, out_valid, zero, op_err;
   logic [W-1:0] alu_result;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [W-1:0] res;
      logic         err;
   } exp_t;
   exp_t q[$];

   alu_seq dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .alu_opcode(alu_opcode), .out_valid(out_valid),
      .out_ready(out_ready), .alu_result(alu_result), .zero(zero), .op_err(op_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      exp_t e;
      logic [63:0] p;
      p = {32'b0, x} * {32'b0, y};
      e.res = '0;
      e.err = 1'b0;
      case (op)
         ALU_OP_AND:   e.res = x & y;
         ALU_OP_OR:    e.res = x | y;
         ALU_OP_ADD:   e.res = x + y;
         ALU_OP_SUB:   e.res = x - y;
         ALU_OP_XOR:   e.res = x ^ y;
         ALU_OP_SLL:   e.res = x << y[4:0];
         ALU_OP_SRL:   e.res = x >> y[4:0];
         ALU_OP_SRA:   e.res = $signed(x) >>> y[4:0];
         ALU_OP_SLT:   e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_OP_SLTU:  e.res = (x < y) ? 32'd1 : 32'd0;
         ALU_OP_MUL:   e.res = p[31:0];
         ALU_OP_MULHU: e.res = p[63:32];
`ifdef ALU_SEQ_DIV_EN
         ALU_OP_DIVU:  e.res = (y == 0) ? 32'hFFFF_FFFF : x / y;
         ALU_OP_REMU:  e.res = (y == 0) ? x : x % y;
`endif
         default:      e.err = 1'b1;
      endcase
      return e;
   endfunction

   // scoreboard: every cycle with out_valid must match the oldest accepted operation
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
      end else begin
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected out_valid", 64'(out_valid), 64'(0));
            end else begin
               chk("sb result", 64'(alu_result), 64'(q[0].res));
               chk("sb zero", 64'(zero), 64'(q[0].res == 0));
               chk("sb op_err", 64'(op_err), 64'(q[0].err));
               if (out_ready) void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(model(alu_opcode, a, b));
      end
   end

   task automatic run(input string nm, input logic [3:0] op, input logic [W-1:0] x,
                      input logic [W-1:0] y, input logic [W-1:0] er, input logic ee, input int el);
      int lat;
      bit got;
      @(posedge clk); #1;
      alu_opcode = op; a = x; b = y; in_valid = 1'b1;
      got = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready) begin got = 1; break; end
      end
      chk({nm, " accepted"}, 64'(got), 64'(1));
      @(posedge clk); #1;
      // scramble inputs: the operation must use the latched operands
      in_valid = 1'b0; a = 32'hA5A5_5A5A; b = 32'h0; alu_opcode = 4'hF;
      lat = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (out_valid) begin lat = i; break; end
      end
      chk({nm, " latency"}, 64'(lat), 64'(el));
      chk({nm, " result"}, 64'(alu_result), 64'(er));
      chk({nm, " zero"}, 64'(zero), 64'(er == 0));
      chk({nm, " op_err"}, 64'(op_err), 64'(ee));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
      $fatal(1, "timeout");
   end

   initial begin
      bit saw;
      // reset with a pending request
      in_valid = 1'b1; alu_opcode = ALU_OP_ADD; a = 32'd1; b = 32'd2;
      repeat (2) @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'(0));
      chk("reset in_ready", 64'(in_ready), 64'(0));
      chk("reset result", 64'(alu_result), 64'(0));
      chk("reset zero", 64'(zero), 64'(1));
      chk("reset op_err", 64'(op_err), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1; in_valid = 1'b0;

      run("add wrap", ALU_OP_ADD, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1);
      run("sub", ALU_OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1);
      run("and", ALU_OP_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1);
      run("or", ALU_OP_OR, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1'b0, 1);
      run("xor", ALU_OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1);
      run("sll", ALU_OP_SLL, 32'h0000_0003, 32'h0000_0024, 32'h0000_0030, 1'b0, 1);
      run("srl", ALU_OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1);
      run("sra", ALU_OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1);
      run("sltu", ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 1'b0, 1);
      run("mul", ALU_OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b0, 33);
      run("mulhu", ALU_OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h1, 1'b0, 33);
      run("mul max", ALU_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, 33);
      run("mulhu max", ALU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33);
`ifdef ALU_SEQ_DIV_EN
      run("divu", ALU_OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 33);
      run("remu", ALU_OP_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 33);
      run("divu big", ALU_OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 1'b0, 33);
      run("divu by 0", ALU_OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0, 1);
      run("remu by 0", ALU_OP_REMU, 32'd5, 32'd0, 32'd5, 1'b0, 1);
`else
      run("divu absent", ALU_OP_DIVU, 32'd100, 32'd7, 32'h0, 1'b1, 1);
      run("remu absent", ALU_OP_REMU, 32'd5, 32'd0, 32'h0, 1'b1, 1);
`endif

      // backpressure: result held, new request waits, then back-to-back
      @(posedge clk); #1;
      out_ready = 1'b0; alu_opcode = ALU_OP_ADD; a = 32'd3; b = 32'd4; in_valid = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      alu_opcode = ALU_OP_SLT; a = 32'hFFFF_FFFF; b = 32'd1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp held valid", 64'(out_valid), 64'(1));
         chk("bp held result", 64'(alu_result), 64'(7));
         chk("bp in_ready low", 64'(in_ready), 64'(0));
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp release in_ready", 64'(in_ready), 64'(1));
      chk("bp release result", 64'(alu_result), 64'(7));
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp slt valid", 64'(out_valid), 64'(1));
      chk("bp slt result", 64'(alu_result), 64'(1));

      // reset in the middle of a multiply
      @(posedge clk); #1;
      alu_opcode = ALU_OP_MUL; a = 32'd6; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort idle in_ready", 64'(in_ready), 64'(1));
      saw = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw = 1;
      end
      chk("abort no result", 64'(saw), 64'(0));
      run("mul after abort", ALU_OP_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 33);

      run("undef 1111", 4'b1111, 32'd9, 32'd9, 32'h0, 1'b1, 1);
      run("undef 1110", 4'b1110, 32'd1, 32'd2, 32'h0, 1'b1, 1);
      run("slt neg", ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);

      @(posedge clk); #1;
      @(negedge clk);
      chk("scoreboard drained", 64'(q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
